// File: rtl/synth_param_bank.sv
// ---------------------------------------------------------------------------
// synth_param_bank
//
// Bank of NUM_PARAMS saturating synth control registers (octave, amplitude,
// A/D/S/R, ...). A select index picks one register. The inc/dec buttons step
// that register once on press, then auto-repeat while the button is held:
// the first repeat comes after HOLD_CYCLES, and later repeats come every
// REPEAT_CYCLES. A direct load port writes absolute values, clipped to the
// register's upper limit.
//
// Parameters:
//   NUM_PARAMS    number of registers (>= 2)
//   WIDTH         bits per register (>= 4)
//   SEL_W         select width, 2**SEL_W >= NUM_PARAMS
//   DEFAULTS      packed reset values, index 0 in the LSBs
//   MAX_VALS      packed per-register upper limits, index 0 in the LSBs
//   HOLD_CYCLES   hold time before auto-repeat starts
//   REPEAT_CYCLES interval between auto-repeat steps
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   sel          register index used by inc/dec/load
//   inc, dec     button levels, already synchronised to clk
//   load         one-cycle strobe that writes load_value to register sel
//   load_value   absolute value for load
//   params_flat  all registers, index i at [i*WIDTH +: WIDTH]
//   sel_value    register at sel (combinational), 0 for an unused index
//   sel_nibble   top four bits of sel_value, for the HEX decoder
//   changed      registered one-cycle pulse when a register value changed
//   sat          registered one-cycle pulse when a step or load was clipped
// ---------------------------------------------------------------------------
module synth_param_bank #(
  parameter int                          NUM_PARAMS    = 6,
  parameter int                          WIDTH         = 6,
  parameter int                          SEL_W         = 3,
  parameter logic [NUM_PARAMS*WIDTH-1:0] DEFAULTS      = {6'd63, 6'd63, 6'd0, 6'd63, 6'd63, 6'd4},
  parameter logic [NUM_PARAMS*WIDTH-1:0] MAX_VALS      = {6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd7},
  parameter int                          HOLD_CYCLES   = 25_000_000,
  parameter int                          REPEAT_CYCLES = 5_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        inc,
  input  logic                        dec,
  input  logic                        load,
  input  logic [WIDTH-1:0]            load_value,
  output logic [NUM_PARAMS*WIDTH-1:0] params_flat,
  output logic [WIDTH-1:0]            sel_value,
  output logic [3:0]                  sel_nibble,
  output logic                        changed,
  output logic                        sat
);

  // The counter has to reach the larger of the two intervals.
  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  // Direction code: bit 0 = up, bit 1 = down, 00 = no direction.
  localparam logic [1:0] DIR_NONE = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT,
    ST_WAIT_REL
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             dir_q, dir_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [WIDTH-1:0]       regs_q [NUM_PARAMS];
  logic [WIDTH-1:0]       regs_d [NUM_PARAMS];
  logic                   changed_q, changed_d;
  logic                   sat_q, sat_d;

  logic [1:0]             dir;
  logic                   step_req;
  logic                   sel_valid;
  logic [WIDTH-1:0]       cur_val;
  logic [WIDTH-1:0]       cur_max;
  logic [WIDTH:0]         up_ext;
  logic [WIDTH:0]         dn_ext;
  logic [WIDTH-1:0]       new_val;
  logic                   write_en;

  // Reset value of register i, clipped to that register's upper limit.
  function automatic logic [WIDTH-1:0] reset_val(input int i);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] m;
    d = DEFAULTS[i*WIDTH +: WIDTH];
    m = MAX_VALS[i*WIDTH +: WIDTH];
    return (d > m) ? m : d;
  endfunction

  // Pressing both buttons at once is treated the same as releasing both.
  assign dir = {dec & ~inc, inc & ~dec};

  // Press / hold / auto-repeat controller. The direction and select index
  // are latched at the press. If either one changes while the button is
  // held, the controller waits for a full release, so it never starts
  // stepping a different register or in the other direction by accident.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    sel_d    = sel_q;
    step_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dir != DIR_NONE) begin
          step_req = 1'b1;
          cnt_d    = '0;
          dir_d    = dir;
          sel_d    = sel;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (dir == DIR_NONE) begin
          state_d = ST_IDLE;
        end else if ((dir != dir_q) || (sel != sel_q)) begin
          state_d = ST_WAIT_REL;
        end else if (cnt_q == ((state_q == ST_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
          step_req = 1'b1;
          cnt_d    = '0;
          state_d  = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (dir == DIR_NONE) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Select mux. This loop is written with an explicit compare, so an
  // index past the last register never reads out of range. For such an
  // index it leaves sel_valid low and returns 0.
  always_comb begin
    cur_val   = '0;
    cur_max   = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (sel == SEL_W'(i)) begin
        cur_val   = regs_q[i];
        cur_max   = MAX_VALS[i*WIDTH +: WIDTH];
        sel_valid = 1'b1;
      end
    end
  end

  // Both step results carry one extra bit. Bit WIDTH of dn_ext is the
  // borrow out of zero. up_ext is compared against the limit with no wrap.
  assign up_ext = {1'b0, cur_val} + {{WIDTH{1'b0}}, 1'b1};
  assign dn_ext = {1'b0, cur_val} - {{WIDTH{1'b0}}, 1'b1};

  // Register update. A load wins over a step in the same cycle; the step
  // request is then dropped, but the controller above has still advanced.
  // A write that leaves the value unchanged does not raise changed.
  always_comb begin
    regs_d    = regs_q;
    changed_d = 1'b0;
    sat_d     = 1'b0;
    new_val   = cur_val;
    write_en  = 1'b0;
    if (sel_valid) begin
      if (load) begin
        write_en = 1'b1;
        if (load_value > cur_max) begin
          new_val = cur_max;
          sat_d   = 1'b1;
        end else begin
          new_val = load_value;
        end
      end else if (step_req) begin
        if (dir[0]) begin
          if (up_ext > {1'b0, cur_max}) begin
            sat_d = 1'b1;
          end else begin
            new_val  = up_ext[WIDTH-1:0];
            write_en = 1'b1;
          end
        end else begin
          if (dn_ext[WIDTH]) begin
            sat_d = 1'b1;
          end else begin
            new_val  = dn_ext[WIDTH-1:0];
            write_en = 1'b1;
          end
        end
      end
      if (write_en && (new_val != cur_val)) begin
        changed_d = 1'b1;
      end
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if (write_en && (sel == SEL_W'(i))) begin
          regs_d[i] = new_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dir_q     <= DIR_NONE;
      sel_q     <= '0;
      changed_q <= 1'b0;
      sat_q     <= 1'b0;
      for (int i = 0; i < NUM_PARAMS; i++) begin
        regs_q[i] <= reset_val(i);
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      sel_q     <= sel_d;
      changed_q <= changed_d;
      sat_q     <= sat_d;
      regs_q    <= regs_d;
    end
  end

  always_comb begin
    params_flat = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      params_flat[i*WIDTH +: WIDTH] = regs_q[i];
    end
  end

  assign sel_value  = cur_val;
  assign sel_nibble = cur_val[WIDTH-1 -: 4];
  assign changed    = changed_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_synth_param_bank.sv
// ---------------------------------------------------------------------------
// tb_synth_param_bank
//
// Directed bench for synth_param_bank, built with short hold and repeat
// times. Each cycle, an expected snapshot of the register bank and the
// status outputs is queued as the stimulus is driven. The snapshot is
// popped and compared one time unit after the active clock edge.
// ---------------------------------------------------------------------------
module tb_synth_param_bank;

  localparam int NP = 6;
  localparam int W  = 6;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [SW-1:0]     sel;
  logic              inc;
  logic              dec;
  logic              load;
  logic [W-1:0]      load_value;
  logic [NP*W-1:0]   params_flat;
  logic [W-1:0]      sel_value;
  logic [3:0]        sel_nibble;
  logic              changed;
  logic              sat;

  typedef struct {
    string           tag;
    logic [NP*W-1:0] flat;
    logic [W-1:0]    selv;
    logic [3:0]      nib;
    logic            chg;
    logic            st;
  } exp_t;

  exp_t sb[$];
  int   exp_regs[NP];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  synth_param_bank #(
    .NUM_PARAMS   (NP),
    .WIDTH        (W),
    .SEL_W        (SW),
    .DEFAULTS     ({6'd63, 6'd63, 6'd0, 6'd63, 6'd63, 6'd4}),
    .MAX_VALS     ({6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd7}),
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .inc        (inc),
    .dec        (dec),
    .load       (load),
    .load_value (load_value),
    .params_flat(params_flat),
    .sel_value  (sel_value),
    .sel_nibble (sel_nibble),
    .changed    (changed),
    .sat        (sat)
  );

  // A press is stepped at once; while held, steps follow at 8 and then every 4.
  function automatic bit is_step(input int t);
    return (t == 0) || ((t >= 8) && (((t - 8) % 4) == 0));
  endfunction

  function automatic logic [NP*W-1:0] pack_regs();
    logic [NP*W-1:0] f;
    f = '0;
    for (int i = 0; i < NP; i++) f[i*W +: W] = W'(exp_regs[i]);
    return f;
  endfunction

  task automatic set_defaults();
    exp_regs[0] = 4;  exp_regs[1] = 63; exp_regs[2] = 63;
    exp_regs[3] = 0;  exp_regs[4] = 63; exp_regs[5] = 63;
  endtask

  // Queue the expected outcome of the current inputs, then clock once.
  task automatic applyStimulus(input string tag, input logic chg, input logic st);
    exp_t e;
    logic [W-1:0] sv;
    sv = (int'(sel) < NP) ? W'(exp_regs[sel]) : '0;
    e.tag  = tag;
    e.flat = pack_regs();
    e.selv = sv;
    e.nib  = sv[W-1 -: 4];
    e.chg  = chg;
    e.st   = st;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (params_flat === e.flat) else begin
      failures++;
      $error("[TB] FAIL %s params_flat observed=%h expected=%h", e.tag, params_flat, e.flat);
    end
    checks++;
    assert (changed === e.chg) else begin
      failures++;
      $error("[TB] FAIL %s changed observed=%b expected=%b", e.tag, changed, e.chg);
    end
    checks++;
    assert (sat === e.st) else begin
      failures++;
      $error("[TB] FAIL %s sat observed=%b expected=%b", e.tag, sat, e.st);
    end
    checks++;
    assert (sel_value === e.selv) else begin
      failures++;
      $error("[TB] FAIL %s sel_value observed=%0d expected=%0d", e.tag, sel_value, e.selv);
    end
    checks++;
    assert (sel_nibble === e.nib) else begin
      failures++;
      $error("[TB] FAIL %s sel_nibble observed=%h expected=%h", e.tag, sel_nibble, e.nib);
    end
  endtask

  task automatic cyc(input string tag, input logic chg, input logic st);
    applyStimulus(tag, chg, st);
    checkOutput();
  endtask

  initial begin
    reset = 1'b0; sel = '0; inc = 1'b0; dec = 1'b0;
    load = 1'b0; load_value = '0;
    set_defaults();

    // Reset and the default values
    cyc("reset_hold", 1'b0, 1'b0);
    cyc("reset_hold", 1'b0, 1'b0);
    reset = 1'b1;
    cyc("reset_release", 1'b0, 1'b0);

    // Single presses on reg0 up to its limit of 7, then a blocked press
    sel = 3'd0;
    for (int p = 0; p < 4; p++) begin
      inc = 1'b1;
      if (p < 3) begin
        exp_regs[0] = 5 + p;
        cyc("inc_press", 1'b1, 1'b0);
      end else begin
        cyc("inc_press_sat", 1'b0, 1'b1);
      end
      cyc("inc_held", 1'b0, 1'b0);
      inc = 1'b0;
      cyc("inc_low", 1'b0, 1'b0);
      cyc("inc_low", 1'b0, 1'b0);
    end

    // Auto-repeat on reg3 at zero: every step is blocked
    sel = 3'd3; dec = 1'b1;
    for (int t = 0; t < 30; t++) cyc("dec_floor", 1'b0, is_step(t));
    dec = 1'b0;
    cyc("dec_release", 1'b0, 1'b0);

    // Auto-repeat on reg1: 63 down to 56
    sel = 3'd1; dec = 1'b1;
    for (int t = 0; t < 30; t++) begin
      if (is_step(t)) begin
        exp_regs[1] = exp_regs[1] - 1;
        cyc("dec_repeat", 1'b1, 1'b0);
      end else begin
        cyc("dec_repeat", 1'b0, 1'b0);
      end
    end
    dec = 1'b0;
    cyc("dec_release", 1'b0, 1'b0);
    checks++;
    assert (params_flat[11:6] === 6'd56) else begin
      failures++;
      $error("[TB] FAIL reg1_after_repeat observed=%0d expected=56", params_flat[11:6]);
    end

    // Select change mid-hold blocks stepping until release
    sel = 3'd3; inc = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (is_step(t)) begin
        exp_regs[3] = exp_regs[3] + 1;
        cyc("inc_reg3", 1'b1, 1'b0);
      end else begin
        cyc("inc_reg3", 1'b0, 1'b0);
      end
    end
    sel = 3'd1;
    for (int t = 0; t < 20; t++) cyc("sel_switch_wait", 1'b0, 1'b0);
    inc = 1'b0;
    cyc("sel_switch_release", 1'b0, 1'b0);
    inc = 1'b1;
    exp_regs[1] = 57;
    cyc("repress", 1'b1, 1'b0);

    // Direction flip mid-hold also waits for release
    exp_regs[1] = 57;
    inc = 1'b0; dec = 1'b1;
    for (int t = 0; t < 10; t++) cyc("flip_wait", 1'b0, 1'b0);
    dec = 1'b0;
    cyc("flip_release", 1'b0, 1'b0);

    // Both buttons together act as released
    inc = 1'b1; dec = 1'b1;
    for (int t = 0; t < 20; t++) cyc("both_pressed", 1'b0, 1'b0);
    inc = 1'b0; dec = 1'b0;
    cyc("both_release", 1'b0, 1'b0);

    // Loads: clip, write, identical value, priority over a step
    sel = 3'd0; load = 1'b1; load_value = 6'd20;
    cyc("load_clip", 1'b0, 1'b1);
    load_value = 6'd3; exp_regs[0] = 3;
    cyc("load_write", 1'b1, 1'b0);
    cyc("load_same", 1'b0, 1'b0);
    load_value = 6'd5; inc = 1'b1; exp_regs[0] = 5;
    cyc("load_vs_step", 1'b1, 1'b0);
    load = 1'b0;
    cyc("hold_after_load", 1'b0, 1'b0);
    inc = 1'b0;
    cyc("release_after_load", 1'b0, 1'b0);

    // Unused select indices ignore loads and steps
    sel = 3'd6; load = 1'b1; load_value = 6'd1;
    cyc("load_bad_sel", 1'b0, 1'b0);
    load = 1'b0; inc = 1'b1;
    for (int t = 0; t < 10; t++) cyc("inc_bad_sel", 1'b0, 1'b0);
    inc = 1'b0;
    cyc("bad_sel_release", 1'b0, 1'b0);
    sel = 3'd7; dec = 1'b1;
    cyc("dec_bad_sel", 1'b0, 1'b0);
    dec = 1'b0;
    cyc("bad_sel_release", 1'b0, 1'b0);

    // Reset during auto-repeat, button still held afterwards
    sel = 3'd3; inc = 1'b1;
    for (int t = 0; t < 13; t++) begin
      if (is_step(t)) begin
        exp_regs[3] = exp_regs[3] + 1;
        cyc("repeat_before_reset", 1'b1, 1'b0);
      end else begin
        cyc("repeat_before_reset", 1'b0, 1'b0);
      end
    end
    reset = 1'b0;
    set_defaults();
    cyc("reset_mid_hold", 1'b0, 1'b0);
    cyc("reset_mid_hold", 1'b0, 1'b0);
    reset = 1'b1;
    exp_regs[3] = 1;
    cyc("post_reset_step", 1'b1, 1'b0);
    cyc("post_reset_hold", 1'b0, 1'b0);
    inc = 1'b0;
    cyc("post_reset_release", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
